// File: rtl/axi_ram_arbiter.sv
// Arbiter sharing one AXI RAM port between instruction fetch (read-only) and the MEM stage (read/write).
// Optional build macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed MEM-over-IF priority.
module axi_ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic                mem_wen,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_rvalid,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_bdone,
  output logic [ADDR_W-1:0]   ram_araddr,
  output logic                ram_arvalid,
  input  logic                ram_arready,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [ADDR_W-1:0]   ram_awaddr,
  output logic                ram_awvalid,
  input  logic                ram_awready,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_wstrb,
  output logic                ram_wvalid,
  input  logic                ram_wready,
  input  logic                ram_bvalid
);

  // state | meaning
  // IDLE  | no transaction, arbitrate on requests
  // AR    | read address presented, waiting for arready
  // RD    | counting RD_LAT cycles until ram_rdata is valid
  // AW    | write address and data presented, each handshaken independently
  // B     | waiting for the write response
  // RESP  | one-cycle response pulse to the owner
  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_RD, S_AW, S_B, S_RESP
  } state_t;

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t              state_q, state_d;
  logic                owner_mem_q, owner_mem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                arvalid_q, arvalid_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                mem_rvalid_q, mem_rvalid_d;
  logic                mem_bdone_q, mem_bdone_d;
  logic                grant_mem;
  logic                aw_done, w_done;

  // owner_mem_q keeps the last grantee after completion, so it doubles as the
  // round-robin history; its reset value (IF) lets MEM win the first contention.
`ifdef ARB_ROUND_ROBIN_EN
  assign grant_mem = mem_req && (!if_req || !owner_mem_q);
`else
  assign grant_mem = mem_req;
`endif

  assign aw_done = !awvalid_q || ram_awready;
  assign w_done  = !wvalid_q  || ram_wready;

  always_comb begin
    state_d      = state_q;
    owner_mem_d  = owner_mem_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    arvalid_d    = arvalid_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_rvalid_d  = 1'b0;
    mem_rvalid_d = 1'b0;
    mem_bdone_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_mem) begin
          owner_mem_d = 1'b1;
          addr_d      = mem_addr;
          if (mem_wen) begin
            wdata_d   = mem_wdata;
            wstrb_d   = mem_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_AW;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_AR;
          end
        end else if (if_req) begin
          owner_mem_d = 1'b0;
          addr_d      = if_addr;
          arvalid_d   = 1'b1;
          state_d     = S_AR;
        end
      end
      S_AR: begin
        if (ram_arready) begin
          arvalid_d = 1'b0;
          cnt_d     = CNT_W'(RD_LAT - 1);
          state_d   = S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == '0) begin
          if (owner_mem_q) begin
            mem_rdata_d  = ram_rdata;
            mem_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = ram_rdata;
            if_rvalid_d = 1'b1;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_AW: begin
        if (awvalid_q && ram_awready) awvalid_d = 1'b0;
        if (wvalid_q && ram_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done)        state_d   = S_B;
      end
      S_B: begin
        if (ram_bvalid) begin
          mem_bdone_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_mem_q  <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      arvalid_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_rvalid_q  <= 1'b0;
      mem_rvalid_q <= 1'b0;
      mem_bdone_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_mem_q  <= owner_mem_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      arvalid_q    <= arvalid_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_rvalid_q  <= if_rvalid_d;
      mem_rvalid_q <= mem_rvalid_d;
      mem_bdone_q  <= mem_bdone_d;
    end
  end

  assign if_rvalid   = if_rvalid_q;
  assign if_rdata    = if_rdata_q;
  assign mem_rvalid  = mem_rvalid_q;
  assign mem_rdata   = mem_rdata_q;
  assign mem_bdone   = mem_bdone_q;
  assign ram_araddr  = addr_q;
  assign ram_arvalid = arvalid_q;
  assign ram_awaddr  = addr_q;
  assign ram_awvalid = awvalid_q;
  assign ram_wdata   = wdata_q;
  assign ram_wstrb   = wstrb_q;
  assign ram_wvalid  = wvalid_q;

endmodule
